// File: rtl/digit_serial_adder.sv
// ----------------------------------------------------------------------------
// digit_serial_adder : two-bit-per-cycle serial adder with valid/ready handshake
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module digit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SLICES = WIDTH / 2;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r, sum_shift;
  logic             carry, cout_r;
  logic [2:0]       slice_sum;
  logic             last_slice;

  assign slice_sum  = {1'b0, a_sh[1:0]} + {1'b0, b_sh[1:0]} + {2'b00, carry};
  assign last_slice = (cnt == LAST_SLICE);

  // New slice enters at the MSB end so the result ends up LSB-aligned.
  generate
    if (WIDTH > 2) begin : g_shift_wide
      assign sum_shift = {slice_sum[1:0], sum_r[WIDTH-1:2]};
    end else begin : g_shift_single
      assign sum_shift = slice_sum[1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum_r <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 2;
          b_sh  <= b_sh >> 2;
          carry <= slice_sum[2];
          sum_r <= sum_shift;
          cnt   <= cnt + 1'b1;
          if (last_slice) cout_r <= slice_sum[2];
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

`default_nettype wire
